// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle RV32I-subset fetch/decode controller: fetches over a req/valid
// handshake, decodes into the datapath control bundle and resolves BEQ/BNE.
module fetch_decode_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int PC_BITS    = 16,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [PC_BITS-1:0]    imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  alu_zero,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output logic                  reg_we,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [PC_BITS-1:0]    pc,
  output logic                  illegal
);

  localparam logic [CTRL_BITS-1:0] OP_AND = CTRL_BITS'(4'b0000);
  localparam logic [CTRL_BITS-1:0] OP_OR  = CTRL_BITS'(4'b0001);
  localparam logic [CTRL_BITS-1:0] OP_ADD = CTRL_BITS'(4'b0010);
  localparam logic [CTRL_BITS-1:0] OP_SUB = CTRL_BITS'(4'b0110);
  localparam logic [CTRL_BITS-1:0] OP_SLT = CTRL_BITS'(4'b0111);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   inst_reg;
  logic [PC_BITS-1:0]      pc_reg;
  logic                    imem_req_reg;
  logic [NAME_BITS-1:0]    rs1_reg, rs2_reg, ws_reg;
  logic [CTRL_BITS-1:0]    op_reg;
  logic                    imm_e_reg;
  logic [DATA_WIDTH-1:0]   imm_reg;
  logic                    reg_we_reg, mem_we_reg, mem_re_reg;
  logic                    illegal_reg;
  logic                    is_beq_reg, is_bne_reg;

  logic                    dec_legal;
  logic [NAME_BITS-1:0]    dec_rs1, dec_rs2, dec_ws;
  logic [CTRL_BITS-1:0]    dec_op;
  logic                    dec_imm_e;
  logic [DATA_WIDTH-1:0]   dec_imm;
  logic                    dec_reg_we, dec_mem_we, dec_mem_re;
  logic                    dec_beq, dec_bne;
  logic [2:0]              f3;
  logic [6:0]              f7;
  logic [DATA_WIDTH-1:0]   i_imm, s_imm, b_imm;
  logic                    branch_taken;
  logic [PC_BITS-1:0]      pc_next;

  assign f3    = inst_reg[14:12];
  assign f7    = inst_reg[31:25];
  assign i_imm = {{(DATA_WIDTH-12){inst_reg[31]}}, inst_reg[31:20]};
  assign s_imm = {{(DATA_WIDTH-12){inst_reg[31]}}, inst_reg[31:25], inst_reg[11:7]};
  assign b_imm = {{(DATA_WIDTH-13){inst_reg[31]}}, inst_reg[31], inst_reg[7],
                  inst_reg[30:25], inst_reg[11:8], 1'b0};

  always_comb begin
    dec_legal  = 1'b0;
    dec_rs1    = '0;
    dec_rs2    = '0;
    dec_ws     = '0;
    dec_op     = OP_AND;
    dec_imm_e  = 1'b0;
    dec_imm    = '0;
    dec_reg_we = 1'b0;
    dec_mem_we = 1'b0;
    dec_mem_re = 1'b0;
    dec_beq    = 1'b0;
    dec_bne    = 1'b0;
    case (inst_reg[6:0])
      7'b0110011: begin
        dec_rs1    = inst_reg[19:15];
        dec_rs2    = inst_reg[24:20];
        dec_ws     = inst_reg[11:7];
        dec_reg_we = 1'b1;
        if (f7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (f3)
            3'b000:  dec_op = OP_ADD;
            3'b010:  dec_op = OP_SLT;
            3'b110:  dec_op = OP_OR;
            3'b111:  dec_op = OP_AND;
            default: dec_legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end
      end
      7'b0010011: begin
        dec_rs1    = inst_reg[19:15];
        dec_ws     = inst_reg[11:7];
        dec_imm_e  = 1'b1;
        dec_imm    = i_imm;
        dec_reg_we = 1'b1;
        dec_legal  = 1'b1;
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b010:  dec_op = OP_SLT;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_legal  = (f3 == 3'b010);
        dec_rs1    = inst_reg[19:15];
        dec_ws     = inst_reg[11:7];
        dec_op     = OP_ADD;
        dec_imm_e  = 1'b1;
        dec_imm    = i_imm;
        dec_mem_re = 1'b1;
        dec_reg_we = 1'b1;
      end
      7'b0100011: begin
        dec_legal  = (f3 == 3'b010);
        dec_rs1    = inst_reg[19:15];
        dec_rs2    = inst_reg[24:20];
        dec_op     = OP_ADD;
        dec_imm_e  = 1'b1;
        dec_imm    = s_imm;
        dec_mem_we = 1'b1;
      end
      7'b1100011: begin
        dec_legal = (f3 == 3'b000) || (f3 == 3'b001);
        dec_rs1   = inst_reg[19:15];
        dec_rs2   = inst_reg[24:20];
        dec_op    = OP_SUB;
        dec_imm   = b_imm;
        dec_beq   = (f3 == 3'b000);
        dec_bne   = (f3 == 3'b001);
      end
      default: dec_legal = 1'b0;
    endcase
    // x0 is never a real destination
    if (dec_ws == '0) dec_reg_we = 1'b0;
  end

  assign branch_taken = (is_beq_reg & alu_zero) | (is_bne_reg & ~alu_zero);
  assign pc_next = branch_taken ? pc_reg + imm_reg[PC_BITS-1:0]
                                : pc_reg + PC_BITS'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      inst_reg     <= '0;
      pc_reg       <= RESET_PC;
      imem_req_reg <= 1'b0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      ws_reg       <= '0;
      op_reg       <= '0;
      imm_e_reg    <= 1'b0;
      imm_reg      <= '0;
      reg_we_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_re_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
      is_beq_reg   <= 1'b0;
      is_bne_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            inst_reg     <= imem_data;
            imem_req_reg <= 1'b0;
            state_reg    <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            rs1_reg    <= dec_rs1;
            rs2_reg    <= dec_rs2;
            ws_reg     <= dec_ws;
            op_reg     <= dec_op;
            imm_e_reg  <= dec_imm_e;
            imm_reg    <= dec_imm;
            reg_we_reg <= dec_reg_we;
            mem_we_reg <= dec_mem_we;
            mem_re_reg <= dec_mem_re;
            is_beq_reg <= dec_beq;
            is_bne_reg <= dec_bne;
            state_reg  <= EXEC;
          end else begin
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            ws_reg      <= '0;
            op_reg      <= '0;
            imm_e_reg   <= 1'b0;
            imm_reg     <= '0;
            reg_we_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;
            mem_re_reg  <= 1'b0;
            is_beq_reg  <= 1'b0;
            is_bne_reg  <= 1'b0;
            illegal_reg <= 1'b1;
            state_reg   <= HALT;
          end
        end
        EXEC: begin
          // write strobes last exactly one cycle; the rest of the bundle stays put
          reg_we_reg   <= 1'b0;
          mem_we_reg   <= 1'b0;
          pc_reg       <= pc_next;
          imem_req_reg <= 1'b1;
          state_reg    <= FETCH;
        end
        default: begin
          state_reg <= HALT;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign rs1       = rs1_reg;
  assign rs2       = rs2_reg;
  assign ws        = ws_reg;
  assign op        = op_reg;
  assign imm_e     = imm_e_reg;
  assign imm_d     = imm_reg;
  assign reg_we    = reg_we_reg;
  assign mem_we    = mem_we_reg;
  assign mem_re    = mem_re_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: expected control bundles are queued
// when an instruction is served and compared when the DUT reaches EXEC.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        alu_zero;
  logic [4:0]  rs1, rs2, ws;
  logic [3:0]  op;
  logic        imm_e;
  logic [31:0] imm_d;
  logic        reg_we, mem_we, mem_re;
  logic [15:0] pc;
  logic        illegal;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ws;
    logic [3:0]  op;
    logic        imm_e;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_pc;

  fetch_decode_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_zero(alu_zero),
    .rs1(rs1), .rs2(rs2), .ws(ws), .op(op),
    .imm_e(imm_e), .imm_d(imm_d),
    .reg_we(reg_we), .mem_we(mem_we), .mem_re(mem_re),
    .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) break;
      @(negedge clk);
    end
    check_val("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  // kind: 0 plain, 1 BEQ, 2 BNE
  task automatic run_instr(input logic [31:0] inst, input int waitc, input int kind,
                           input logic zero, input exp_t e);
    exp_t got_e;
    logic taken;
    wait_req();
    check_val("fetch_addr", {16'b0, imem_addr}, {16'b0, model_pc});
    exp_q.push_back(e);
    for (int i = 0; i < waitc; i++) begin
      @(negedge clk);
      check_val("req_hold", {31'b0, imem_req}, 32'd1);
      check_val("addr_hold", {16'b0, imem_addr}, {16'b0, model_pc});
    end
    imem_valid = 1'b1;
    imem_data  = inst;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    check_val("req_drop", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    alu_zero = zero;
    check_val("queue_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      got_e = exp_q.pop_front();
      check_val("rs1", {27'b0, rs1}, {27'b0, got_e.rs1});
      check_val("rs2", {27'b0, rs2}, {27'b0, got_e.rs2});
      check_val("ws", {27'b0, ws}, {27'b0, got_e.ws});
      check_val("op", {28'b0, op}, {28'b0, got_e.op});
      check_val("imm_e", {31'b0, imm_e}, {31'b0, got_e.imm_e});
      check_val("imm_d", imm_d, got_e.imm);
      check_val("reg_we", {31'b0, reg_we}, {31'b0, got_e.reg_we});
      check_val("mem_we", {31'b0, mem_we}, {31'b0, got_e.mem_we});
      check_val("mem_re", {31'b0, mem_re}, {31'b0, got_e.mem_re});
      check_val("illegal", {31'b0, illegal}, 32'd0);
    end
    taken = ((kind == 1) && zero) || ((kind == 2) && !zero);
    $display("txn pc=%h inst=%h kind=%0d zero=%0b taken=%0b", model_pc, inst, kind, zero, taken);
    model_pc = taken ? model_pc + e.imm[15:0] : model_pc + 16'd4;
    @(negedge clk);
    alu_zero = 1'b0;
    check_val("reg_we_one_cycle", {31'b0, reg_we}, 32'd0);
    check_val("mem_we_one_cycle", {31'b0, mem_we}, 32'd0);
    check_val("next_req", {31'b0, imem_req}, 32'd1);
    check_val("next_addr", {16'b0, imem_addr}, {16'b0, model_pc});
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_data  = '0;
    alu_zero   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pc", {16'b0, pc}, 32'd0);
    check_val("rst_req", {31'b0, imem_req}, 32'd0);
    check_val("rst_reg_we", {31'b0, reg_we}, 32'd0);
    check_val("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_val("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check_val("rst_illegal", {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req", {31'b0, imem_req}, 32'd1);
    check_val("post_rst_addr", {16'b0, imem_addr}, 32'd0);
    model_pc = 16'h0000;

    //                     inst          wait kind zero  rs1   rs2   ws    op     ie   imm            rwe   mwe   mre
    run_instr(32'h00500093, 2, 0, 1'b0, '{5'd1 - 5'd1, 5'd0, 5'd1, 4'b0010, 1'b1, 32'd5,         1'b1, 1'b0, 1'b0}); // ADDI x1,x0,5
    run_instr(32'h402081B3, 0, 0, 1'b0, '{5'd1, 5'd2, 5'd3, 4'b0110, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0}); // SUB x3,x1,x2
    run_instr(32'h00100013, 1, 0, 1'b0, '{5'd0, 5'd0, 5'd0, 4'b0010, 1'b1, 32'd1,         1'b0, 1'b0, 1'b0}); // ADDI x0,x0,1
    run_instr(32'h0080A283, 0, 0, 1'b0, '{5'd1, 5'd0, 5'd5, 4'b0010, 1'b1, 32'd8,         1'b1, 1'b0, 1'b1}); // LW x5,8(x1)
    run_instr(32'h00208463, 0, 1, 1'b1, '{5'd1, 5'd2, 5'd0, 4'b0110, 1'b0, 32'd8,         1'b0, 1'b0, 1'b0}); // BEQ taken @0x10
    run_instr(32'hFE50AE23, 3, 0, 1'b0, '{5'd1, 5'd5, 5'd0, 4'b0010, 1'b1, 32'hFFFFFFFC,  1'b0, 1'b1, 1'b0}); // SW x5,-4(x1)
    run_instr(32'h00208463, 0, 1, 1'b0, '{5'd1, 5'd2, 5'd0, 4'b0110, 1'b0, 32'd8,         1'b0, 1'b0, 1'b0}); // BEQ not taken
    run_instr(32'h00209463, 0, 2, 1'b0, '{5'd1, 5'd2, 5'd0, 4'b0110, 1'b0, 32'd8,         1'b0, 1'b0, 1'b0}); // BNE taken
    run_instr(32'h00209463, 0, 2, 1'b1, '{5'd1, 5'd2, 5'd0, 4'b0110, 1'b0, 32'd8,         1'b0, 1'b0, 1'b0}); // BNE not taken
    run_instr(32'hFE000CE3, 0, 1, 1'b1, '{5'd0, 5'd0, 5'd0, 4'b0110, 1'b0, 32'hFFFFFFF8,  1'b0, 1'b0, 1'b0}); // BEQ -8 taken
    run_instr(32'h0041F3B3, 0, 0, 1'b0, '{5'd3, 5'd4, 5'd7, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0}); // AND x7,x3,x4
    run_instr(32'h0020E433, 0, 0, 1'b0, '{5'd1, 5'd2, 5'd8, 4'b0001, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0}); // OR x8,x1,x2
    run_instr(32'hFFF0A493, 0, 0, 1'b0, '{5'd1, 5'd0, 5'd9, 4'b0111, 1'b1, 32'hFFFFFFFF,  1'b1, 1'b0, 1'b0}); // SLTI x9,x1,-1
    run_instr(32'h0F017513, 0, 0, 1'b0, '{5'd2, 5'd0, 5'd10, 4'b0000, 1'b1, 32'h000000F0, 1'b1, 1'b0, 1'b0}); // ANDI x10,x2,0xF0

    // illegal word halts the controller until reset
    wait_req();
    check_val("ill_addr", {16'b0, imem_addr}, {16'b0, model_pc});
    imem_valid = 1'b1;
    imem_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    $display("txn pc=%h inst=ffffffff illegal", model_pc);
    check_val("ill_flag", {31'b0, illegal}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("halt_req", {31'b0, imem_req}, 32'd0);
      check_val("halt_illegal", {31'b0, illegal}, 32'd1);
      check_val("halt_pc", {16'b0, pc}, {16'b0, model_pc});
      check_val("halt_reg_we", {31'b0, reg_we}, 32'd0);
    end

    rst = 1'b1;
    #1;
    check_val("halt_rst_illegal", {31'b0, illegal}, 32'd0);
    check_val("halt_rst_pc", {16'b0, pc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("refetch_req", {31'b0, imem_req}, 32'd1);

    // reset while a fetch is pending; a late valid must be ignored
    rst = 1'b1;
    #1;
    check_val("midfetch_rst_req", {31'b0, imem_req}, 32'd0);
    check_val("midfetch_rst_pc", {16'b0, pc}, 32'd0);
    @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = 32'hFFFF_FFFF;
    rst        = 1'b0;
    @(negedge clk);
    imem_valid = 1'b0;
    check_val("late_valid_req", {31'b0, imem_req}, 32'd1);
    check_val("late_valid_addr", {16'b0, imem_addr}, 32'd0);
    @(negedge clk);
    check_val("late_valid_still_fetch", {31'b0, imem_req}, 32'd1);
    model_pc = 16'h0000;
    run_instr(32'h00500093, 0, 0, 1'b0, '{5'd0, 5'd0, 5'd1, 4'b0010, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0});
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
